// File: rtl/pc_unit.sv
// Fetch-stage program counter: registered PC with fetch handshake, buffered branch
// redirects, exception/eret override and fetch-address fault detection.
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE  = 32'h0000_4000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_valid,
  input  logic [2:0]  jump_op,
  input  logic        zero,
  input  logic [31:0] offset,
  input  logic [25:0] instr_index,
  input  logic [31:0] reg_target,
  input  logic [31:0] direct_target,
  input  logic [31:0] pc_d,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] pc,
  output logic        fetch_adel,
  output logic        flush_f,
  output logic        redirect_pending
);

  localparam logic [31:0] IMEM_END = IMEM_BASE + IMEM_SIZE;

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BEQ    = 3'b001;
  localparam logic [2:0] OP_BNE    = 3'b100;
  localparam logic [2:0] OP_J      = 3'b010;
  localparam logic [2:0] OP_JR     = 3'b011;
  localparam logic [2:0] OP_DIRECT = 3'b101;

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pend_pc_reg;

  logic [31:0] pc_seq;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        taken;
  logic        adv;

  assign pc_seq        = pc_reg + 32'd4;
  assign branch_target = pc_d + 32'd4 + {offset[29:0], 2'b00};
  assign jump_target   = {pc_d[31:28], instr_index, 2'b00};

  // Resolve whether the D-stage instruction redirects fetch, and where to.
  always_comb begin
    taken  = 1'b0;
    target = pc_seq;
    unique case (jump_op)
      OP_BEQ: begin
        taken  = zero;
        target = branch_target;
      end
      OP_BNE: begin
        taken  = !zero;
        target = branch_target;
      end
      OP_J: begin
        taken  = 1'b1;
        target = jump_target;
      end
      OP_JR: begin
        taken  = 1'b1;
        target = reg_target;
      end
      OP_DIRECT: begin
        taken  = 1'b1;
        target = direct_target;
      end
      OP_SEQ: begin
        taken  = 1'b0;
        target = pc_seq;
      end
      default: begin
        taken  = 1'b0;
        target = pc_seq;
      end
    endcase
    taken = taken & d_valid;
  end

  // A faulting fetch never goes to memory, so it completes without if_ready.
  assign fetch_adel = (pc_reg[1:0] != 2'b00) | (pc_reg < IMEM_BASE) | (pc_reg >= IMEM_END);
  assign if_valid   = !reset & !fetch_adel;
  assign adv        = !stall & (if_ready | fetch_adel);

  assign pc               = pc_reg;
  assign flush_f          = !DELAY_SLOT & taken;
  assign redirect_pending = (state_reg == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      state_reg   <= RUN;
      pend_pc_reg <= '0;
    end else if (req) begin
      pc_reg    <= EXC_VECTOR;
      state_reg <= RUN;
    end else if (eret) begin
      pc_reg    <= epc;
      state_reg <= RUN;
    end else if (!DELAY_SLOT) begin
      // Without a delay slot the F instruction is squashed, so redirect at once.
      state_reg <= RUN;
      if (taken) begin
        pc_reg <= target;
      end else if (adv) begin
        pc_reg <= pc_seq;
      end
    end else if (state_reg == HOLD) begin
      // Delay-slot fetch still outstanding; a second taken branch is ignored.
      if (adv) begin
        pc_reg    <= pend_pc_reg;
        state_reg <= RUN;
      end
    end else if (taken) begin
      if (adv) begin
        pc_reg <= target;
      end else begin
        pend_pc_reg <= target;
        state_reg   <= HOLD;
      end
    end else if (adv) begin
      pc_reg <= pc_seq;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one delay-slot instance and one squash-mode instance
// share stimulus; each check prints one line.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        d_valid;
  logic [2:0]  jump_op;
  logic        zero;
  logic [31:0] offset;
  logic [25:0] instr_index;
  logic [31:0] reg_target;
  logic [31:0] direct_target;
  logic [31:0] pc_d;
  logic        if_ready;

  logic        if_valid1, fetch_adel1, flush_f1, pending1;
  logic [31:0] pc1;
  logic        if_valid0, fetch_adel0, flush_f0, pending0;
  logic [31:0] pc0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit #(.DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .d_valid(d_valid), .jump_op(jump_op), .zero(zero), .offset(offset),
    .instr_index(instr_index), .reg_target(reg_target), .direct_target(direct_target),
    .pc_d(pc_d), .if_ready(if_ready), .if_valid(if_valid1), .pc(pc1),
    .fetch_adel(fetch_adel1), .flush_f(flush_f1), .redirect_pending(pending1)
  );

  pc_unit #(.DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .d_valid(d_valid), .jump_op(jump_op), .zero(zero), .offset(offset),
    .instr_index(instr_index), .reg_target(reg_target), .direct_target(direct_target),
    .pc_d(pc_d), .if_ready(if_ready), .if_valid(if_valid0), .pc(pc0),
    .fetch_adel(fetch_adel0), .flush_f(flush_f0), .redirect_pending(pending0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req = 1'b0; eret = 1'b0; epc = '0;
    d_valid = 1'b0; jump_op = 3'b000; zero = 1'b0; offset = '0; instr_index = '0;
    reg_target = '0; direct_target = '0; pc_d = '0; if_ready = 1'b1;

    tick();
    tick();
    check("reset_pc", pc1, 32'h0000_3000);
    check("reset_pending", pending1, 0);
    check("reset_flush", flush_f1, 0);
    check("reset_if_valid", if_valid1, 0);
    reset = 1'b0;
    #1;
    check("run_if_valid", if_valid1, 1);
    tick();
    check("seq_pc1", pc1, 32'h0000_3004);
    tick();
    check("seq_pc2", pc1, 32'h0000_3008);

    // Not-taken bne produces sequential fetch
    d_valid = 1'b1; jump_op = 3'b100; zero = 1'b1; pc_d = 32'h0000_3004; offset = 32'd16;
    tick();
    check("bne_not_taken", pc1, 32'h0000_300C);
    d_valid = 1'b0;

    // Delay-slot beq buffered while imem is busy
    pulse_reset();
    check("async_reset_pc", pc1, 32'h0000_3000);
    tick();
    check("pre_beq_pc", pc1, 32'h0000_3004);
    d_valid = 1'b1; jump_op = 3'b001; zero = 1'b1; pc_d = 32'h0000_3000; offset = 32'd3;
    if_ready = 1'b0;
    tick();
    d_valid = 1'b0;
    check("beq_hold_pc", pc1, 32'h0000_3004);
    check("beq_pending", pending1, 1);
    tick();
    check("beq_hold_pc2", pc1, 32'h0000_3004);
    if_ready = 1'b1;
    tick();
    check("beq_redirect", pc1, 32'h0000_3010);
    check("beq_pending_clr", pending1, 0);

    // Exception overrides a pending redirect
    d_valid = 1'b1; jump_op = 3'b001; zero = 1'b1; pc_d = 32'h0000_3004; offset = 32'd2;
    if_ready = 1'b0;
    tick();
    d_valid = 1'b0;
    check("hold2_pending", pending1, 1);
    req = 1'b1;
    tick();
    check("req_pc", pc1, 32'h0000_4180);
    check("req_pending_clr", pending1, 0);
    req = 1'b0; if_ready = 1'b1;
    tick();
    check("after_req_seq", pc1, 32'h0000_4184);
    req = 1'b1; eret = 1'b1; epc = 32'h0000_3020;
    tick();
    check("req_beats_eret", pc1, 32'h0000_4180);

    // eret ignores stall
    req = 1'b0; stall = 1'b1;
    tick();
    check("eret_stalled", pc1, 32'h0000_3020);
    eret = 1'b0;
    tick();
    check("stall_hold", pc1, 32'h0000_3020);

    // jr to a misaligned address, then fault-driven advance
    stall = 1'b0;
    d_valid = 1'b1; jump_op = 3'b011; reg_target = 32'h0000_3002;
    tick();
    d_valid = 1'b0;
    check("jr_pc", pc1, 32'h0000_3002);
    check("misalign_adel", fetch_adel1, 1);
    check("misalign_if_valid", if_valid1, 0);
    if_ready = 1'b0; stall = 1'b1;
    tick();
    check("adel_stall_hold", pc1, 32'h0000_3002);
    stall = 1'b0;
    tick();
    check("adel_advance", pc1, 32'h0000_3006);

    // Window boundaries
    if_ready = 1'b1;
    d_valid = 1'b1; jump_op = 3'b011; reg_target = 32'h0000_7000;
    tick();
    check("pc_7000", pc1, 32'h0000_7000);
    check("top_adel", fetch_adel1, 1);
    d_valid = 1'b1; jump_op = 3'b101; direct_target = 32'h0000_6FFC;
    tick();
    check("pc_6ffc", pc1, 32'h0000_6FFC);
    check("last_word_ok", fetch_adel1, 0);
    d_valid = 1'b1; jump_op = 3'b101; direct_target = 32'h0000_2FFC;
    tick();
    check("below_base_adel", fetch_adel1, 1);
    d_valid = 1'b0;

    // Squash mode: immediate redirect with flush_f
    pulse_reset();
    check("ds0_reset_pc", pc0, 32'h0000_3000);
    d_valid = 1'b1; jump_op = 3'b010; instr_index = 26'h0000C10; pc_d = 32'h0000_3000;
    #1;
    check("ds0_flush", flush_f0, 1);
    check("ds1_no_flush", flush_f1, 0);
    tick();
    check("ds0_j_pc", pc0, 32'h0000_3040);
    stall = 1'b1; if_ready = 1'b0; jump_op = 3'b101; direct_target = 32'h0000_3100;
    tick();
    check("ds0_stalled_redirect", pc0, 32'h0000_3100);
    check("ds0_no_pending", pending0, 0);
    d_valid = 1'b0;
    #1;
    check("ds0_flush_clr", flush_f0, 0);
    tick();
    check("ds0_stall_hold", pc0, 32'h0000_3100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the pipelined MIPS core, replacing the combinational next-PC mux with a registered PC that has a fetch handshake, buffered branch redirects, exception/eret override and fetch-address fault detection. It sits between the hazard unit, the D-stage branch/jump resolution logic, CP0 and instruction memory, and drives the F-stage PC. Delay-slot or squash semantics are selected by parameter.

## Interface
- RESET_PC, 32'h0000_3000: PC value loaded by reset.
- EXC_VECTOR, 32'h0000_4180: exception entry target.
- IMEM_BASE, 32'h0000_3000: lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000: legal fetch window size in bytes.
- DELAY_SLOT, 1: 1 = MIPS delay slot; 0 = no delay slot, redirect squashes F.

- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of F.
- req  in  1  exception request from CP0.
- eret  in  1  eret executing.
- epc  in  32  eret return address.
- d_valid  in  1  D-stage instruction advances this cycle; qualifies jump_op.
- jump_op  in  3  000 seq, 001 beq, 100 bne, 010 j/jal, 011 jr/jalr, 101 direct target.
- zero  in  1  D-stage compare equal.
- offset  in  32  sign-extended word offset (imm16).
- instr_index  in  26  j/jal index field.
- reg_target  in  32  forwarded rs value for jr/jalr.
- direct_target  in  32  precomputed target for op 101.
- pc_d  in  32  PC of D-stage instruction.
- if_ready  in  1  imem accepts/returns fetch at pc this cycle.
- if_valid  out  1  fetch request for pc.
- pc  out  32  current F-stage PC.
- fetch_adel  out  1  pc misaligned or outside window.
- flush_f  out  1  kill F instruction (DELAY_SLOT=0 only).
- redirect_pending  out  1  a branch target is buffered.

## Operation
- State: RUN (no pending target), HOLD (target in pend_pc). Reset: pc=RESET_PC, state RUN, pend_pc=0; redirect_pending=0, flush_f=0.
- fetch_adel = (pc[1:0]!=0) | (pc < IMEM_BASE) | (pc >= IMEM_BASE+IMEM_SIZE), 32-bit unsigned compare. if_valid = !reset & !fetch_adel.
- adv = !stall & (if_ready | fetch_adel) — faulting fetch completes immediately without memory access.
- taken = d_valid & (op 010|011|101 | (op 001 & zero) | (op 100 & !zero)); not-taken branch causes no redirect.
- Targets (32-bit, wrap mod 2^32): branch = pc_d + 4 + (offset<<2); j = {pc_d[31:28], instr_index, 2'b00}; jr = reg_target; 101 = direct_target.
- Priority per edge: req -> pc=EXC_VECTOR, state RUN (ignores stall, if_ready, pending); else eret -> pc=epc, state RUN; else per mode below.
- DELAY_SLOT=1, RUN: taken & adv -> pc=target; taken & !adv -> pend_pc=target, HOLD; !taken & adv -> pc+4.
- DELAY_SLOT=1, HOLD: adv -> pc=pend_pc, RUN; else hold. taken in HOLD ignored (branch in delay slot undefined; first target wins).
- DELAY_SLOT=0: taken -> pc=target regardless of adv/stall, flush_f=1 same cycle (combinational from taken); HOLD unreachable.
- redirect_pending = (state==HOLD).

## Timing
- pc registered; new pc visible the cycle after the qualifying edge. Redirect latency: 1 cycle after taken when delay slot fetch completes, else 1 cycle after the completing adv.
- if_valid/fetch_adel/flush_f combinational from current state and inputs; no combinational path from if_ready to pc.
- Abandoned fetch (req/eret/DELAY_SLOT=0 redirect) drops the request; imem must accept address change without completion.
- Reset asserted mid-HOLD clears pending immediately (async).

## Test plan
- Reset release, if_ready=1 constant -> pc 0x3000,0x3004,0x3008 on successive cycles; if_valid=1.
- DELAY_SLOT=1, beq zero=1 at pc_d=0x3000, offset=3, if_ready=0 two cycles -> redirect_pending=1, pc holds 0x3004, then 0x3010 after if_ready=1.
- HOLD with pending 0x3010 and req=1 -> pc=0x4180, redirect_pending=0; req with eret same cycle -> 0x4180.
- eret with epc=0x3020 while stall=1 -> pc=0x3020 next cycle.
- jr reg_target=0x3002 -> fetch_adel=1, if_valid=0, pc advances to 0x3006 on !stall; pc=0x7000 also flags fetch_adel.
- DELAY_SLOT=0, j instr_index=0x0C10 at pc_d=0x3000 -> flush_f=1 that cycle, pc=0x3040 next cycle.
